// File: rtl/s2_result_collector.sv
// s2_result_collector: sequences the stage-2 datapath over every filter/position and captures results into a 4x6x6 buffer
//   clk, rst_n            clock and synchronous active-low reset
//   start                 run request, accepted only in IDLE
//   busy, done            busy in RUN/DRAIN, done pulses for one cycle at completion
//   proc_dir/counter/valid  address issued to the combinational processing block
//   res_in                result for the address issued LAT cycles earlier
//   rd_en/addr/data/valid registered read port, flat index dir*36+pos, out of range reads 0
module s2_result_collector #(
    parameter int NFILT  = 4,
    parameter int OROWS  = 6,
    parameter int OCOLS  = 6,
    parameter int DWIDTH = 36,
    parameter int LAT    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               proc_dir,
    output logic [5:0]               proc_counter,
    output logic                     proc_valid,
    input  logic signed [DWIDTH-1:0] res_in,
    input  logic                     rd_en,
    input  logic [7:0]               rd_addr,
    output logic signed [DWIDTH-1:0] rd_data,
    output logic                     rd_valid
);
    localparam int DEPTH = NFILT * OROWS * OCOLS;
    localparam int RW = $clog2(OROWS);
    localparam int CW = $clog2(OCOLS);
    localparam logic [1:0]    DMAX = 2'(NFILT - 1);
    localparam logic [RW-1:0] RMAX = RW'(OROWS - 1);
    localparam logic [CW-1:0] CMAX = CW'(OCOLS - 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [1:0]    dir;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [1:0]    dcnt;
    logic          iss;
    logic          last;
    logic [7:0]    ia;
    logic          cap_v;
    logic [7:0]    cap_a;
    logic signed [DWIDTH-1:0] mem [DEPTH];
    assign iss  = state == RUN;
    assign last = iss && dir == DMAX && row == RMAX && col == CMAX;
    assign ia   = 8'(dir) * 8'(OROWS * OCOLS) + 8'(row) * 8'(OCOLS) + 8'(col);
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_nx;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = start ? RUN : IDLE;
            RUN:   state_nx = !last ? RUN : (LAT == 0) ? DONE : DRAIN;
            DRAIN: state_nx = (dcnt == 2'(LAT - 1)) ? DONE : DRAIN;
            DONE:  state_nx = IDLE;
        endcase
    end
    always_comb begin
        busy         = state == RUN || state == DRAIN;
        done         = state == DONE;
        proc_valid   = iss;
        proc_dir     = iss ? dir : '0;
        proc_counter = iss ? 6'(row) * 6'(OCOLS) + 6'(col) : '0;
    end
    // Counters sit at zero outside RUN so every run starts from position 0.
    always_ff @(posedge clk) begin
        if (!rst_n || !iss) begin
            dir <= '0;
            row <= '0;
            col <= '0;
        end else begin
            col <= (col == CMAX) ? '0 : col + CW'(1);
            row <= (col != CMAX) ? row : (row == RMAX) ? '0 : row + RW'(1);
            dir <= last ? '0 : (col == CMAX && row == RMAX) ? dir + 2'd1 : dir;
        end
    end
    always_ff @(posedge clk) begin
        dcnt <= (!rst_n || state != DRAIN) ? 2'd0 : dcnt + 2'd1;
    end
    // Delay line pairs each issued address with the result that arrives LAT cycles later.
    if (LAT == 0) begin : g_nodly
        assign cap_v = iss;
        assign cap_a = ia;
    end else begin : g_dly
        logic [LAT-1:0] dv;
        logic [7:0]     da [LAT];
        always_ff @(posedge clk) begin
            dv[0] <= rst_n && iss;
            da[0] <= ia;
            for (int i = 1; i < LAT; i++) begin
                dv[i] <= rst_n && dv[i-1];
                da[i] <= da[i-1];
            end
        end
        assign cap_v = dv[LAT-1];
        assign cap_a = da[LAT-1];
    end
    always_ff @(posedge clk) begin
        if (rst_n && cap_v)
            mem[cap_a] <= res_in;
    end
    // Read sees the pre-write value of an entry captured in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= (rd_addr < 8'(DEPTH)) ? mem[rd_addr] : '0;
        end
    end
endmodule

// File: doc/s2_result_collector.md
# s2_result_collector

Sequencing and capture companion for the stage-2 convolution datapath. On `start`, it walks every filter and every output position of the 6×6 stage-2 output map, driving `proc_dir` and `proc_counter` into the combinational stage-2 processing block. It captures the single addressed result per position into a 4×6×6 output buffer and exposes that buffer through a registered read port. It sits between the stage-2 processing block and the next layer's loader, and is the only writer of the stage-2 output tensor.

## Interface
Parameters:
- `NFILT`, 4: number of filters; one `proc_dir` value per filter.
- `OROWS`, 6: output rows per filter.
- `OCOLS`, 6: output columns per filter.
- `DWIDTH`, 36: signed result width.
- `LAT`, 0: cycles from issued address to valid `res_in`, range 0..3.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  run request; accepted only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse at run completion.
- `proc_dir`  out  2  filter index issued to the datapath.
- `proc_counter`  out  6  linear position issued, row*OCOLS+col, 0..35.
- `proc_valid`  out  1  high in every issue cycle.
- `res_in`  in  DWIDTH signed  result for the address issued LAT cycles earlier.
- `rd_en`  in  1  buffer read request.
- `rd_addr`  in  8  flat index dir*36+pos, 0..143.
- `rd_data`  out  DWIDTH signed  registered read data.
- `rd_valid`  out  1  high one cycle after `rd_en`.

## Operation
- FSM states:
  - IDLE: wait for `start`.
  - RUN: issue 144 addresses.
  - DRAIN: wait LAT cycles; skipped when LAT=0.
  - DONE: one cycle, then return to IDLE.
- Issue order is filter-major, then row, then column. Counters wrap as follows: col 5→0 increments row; row 5→0 increments dir; dir=3, row=5, col=5 is the last issue, after which the FSM goes to DRAIN or DONE.
- `proc_counter` = row*6+col, computed from internal row/col counters. It is never a bit-concatenation of them.
- Capture uses an LAT-deep shift register carrying {valid, flat address}:
  - Write address is dir*36+row*6+col of the delayed issue.
  - Writes occur at the clock edge ending the cycle in which the delayed valid is high.
  - LAT=0 means capture in the issue cycle itself.
- Buffer stores `res_in` at full DWIDTH, unmodified. There is no clamping or sign change; negative values are stored as-is.
- Buffer contents are not reset. A complete run writes all 144 entries exactly once.
- `start` is ignored in RUN, DRAIN and DONE; it is not queued. `start` held high continuously launches a new run on the IDLE cycle after each DONE.
- Read port:
  - Usable in any state.
  - A read of an entry while it is being written in the same cycle returns the old value.
  - `rd_addr` ≥ 144 returns 0.
  - Reads during a run may return stale data; the consumer reads only after `done`.
- Reset mid-run: FSM goes to IDLE, counters and delay-line valid bits are cleared, no `done` is generated, and buffer contents are left partially updated.

## Timing
- Reset values:
  - `busy`, `done`, `proc_valid`, `rd_valid` = 0.
  - `proc_dir`, `proc_counter` = 0.
  - `rd_data` = 0.
- Cycle 0 is the cycle in which `start` is high in IDLE.
- Cycles 1..144: RUN. `proc_valid`=1 and `busy`=1. Cycle n issues flat address n-1.
- Cycles 145..144+LAT: DRAIN. `proc_valid`=0, `busy`=1.
- Cycle 145+LAT: DONE. `done`=1 and `busy`=0.
- Cycle 146+LAT: IDLE; the earliest cycle a new `start` is accepted.
- Outside RUN, `proc_dir` and `proc_counter` hold 0.
- Read latency is 1: `rd_en` in cycle k gives `rd_data` and `rd_valid` in cycle k+1. `rd_data` holds its value when `rd_en`=0.

## Test plan
- LAT=0, model `res_in` = dir*1000+pos. Start at cycle 0: `done` pulses at cycle 145, and `proc_valid` counts exactly 144 cycles. Read back addr 0→0, addr 37→1001, addr 143→3035.
- LAT=2 with a two-stage delayed model: `done` pulses at cycle 147, buffer contents are identical to the LAT=0 run, and `busy` is high for cycles 1..146.
- `start` pulsed again at cycles 10 and 145: both ignored, exactly one `done` results. `start` held high: the second run's first issue lands at cycle 147 (LAT=0).
- Assert `rst_n`=0 at cycle 50: from the next cycle `busy`=0, `proc_valid`=0, and no `done` follows. A new run then completes normally and overwrites all 144 entries.
- Model returns -5 for every position: every read returns -5 at full 36-bit width.
- `rd_en` with addr 144 and 255: `rd_data`=0 and `rd_valid`=1 one cycle later. With `rd_en`=0, `rd_data` holds its previous value.
